// File: rtl/bcd_seq_display.sv
// Iterative double-dabble binary-to-BCD converter with active-low 7-segment decode.
// Start/busy/done handshake, leading-zero blanking and overflow dash display.
module bcd_seq_display #(
    parameter int N        = 10,
    parameter int DIGITS   = 4,
    parameter int BLANK_LZ = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [N-1:0]          bin_in,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [7*DIGITS-1:0]   seg_out
);

    localparam int ID = N / 3 + 1;
    localparam int MD = (ID > DIGITS) ? ID : DIGITS;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [N-1:0]        r_bin;
    logic [4*ID-1:0]     r_bcd;
    logic [CW-1:0]       r_cnt;
    logic                r_ovf;
    logic [4*DIGITS-1:0] r_bcd_out;
    logic [7*DIGITS-1:0] r_seg_out;

    logic [4*ID-1:0]     w_adj;
    logic [4*ID+N-1:0]   w_cat;
    logic [4*MD-1:0]     w_dig;
    logic                w_last;
    logic                w_accept;
    logic                w_ovf;
    logic                w_lead;
    logic [4*DIGITS-1:0] w_bcd_o;
    logic [7*DIGITS-1:0] w_seg_o;

    function automatic logic [6:0] f_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign w_last   = (r_cnt == CW'(N - 1));
    assign w_accept = start && (r_state != S_SHIFT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_next_state = S_SHIFT;
            S_SHIFT: if (w_last) w_next_state = S_DONE;
            S_DONE:  w_next_state = start ? S_SHIFT : S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == S_SHIFT);
        done = (r_state == S_DONE);
    end

    // Add-3 on every digit >= 5, then shift the whole {bcd,bin} pair left.
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < ID; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5)
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
        w_cat = {w_adj, r_bin} << 1;
    end

    always_comb begin
        w_dig         = '0;
        w_dig[4*ID-1:0] = w_cat[4*ID+N-1:N];
        w_ovf         = 1'b0;
        for (int i = DIGITS; i < MD; i++) begin
            if (w_dig[4*i +: 4] != 4'd0) w_ovf = 1'b1;
        end
        w_bcd_o = w_dig[4*DIGITS-1:0];
    end

    // Scan from the top digit so w_lead means "this and all higher digits are zero".
    always_comb begin
        w_seg_o = '1;
        w_lead  = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (w_dig[4*i +: 4] != 4'd0) w_lead = 1'b0;
            if (w_ovf)
                w_seg_o[7*i +: 7] = 7'b1111110;
            else if ((BLANK_LZ != 0) && (i > 0) && w_lead)
                w_seg_o[7*i +: 7] = 7'b1111111;
            else
                w_seg_o[7*i +: 7] = f_seg(w_dig[4*i +: 4]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bin <= '0;
            r_bcd <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_bin <= bin_in;
            r_bcd <= '0;
            r_cnt <= '0;
        end else if (r_state == S_SHIFT) begin
            r_bin <= w_cat[N-1:0];
            r_bcd <= w_cat[4*ID+N-1:N];
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf     <= 1'b0;
            r_bcd_out <= '0;
            r_seg_out <= '1;
        end else if ((r_state == S_SHIFT) && w_last) begin
            r_ovf     <= w_ovf;
            r_bcd_out <= w_bcd_o;
            r_seg_out <= w_seg_o;
        end
    end

    assign ovf     = r_ovf;
    assign bcd_out = r_bcd_out;
    assign seg_out = r_seg_out;

endmodule
